// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder and its boot loader.
package imem_pkg;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_t;

  localparam int unsigned IMEM_WORD_BYTES = 4;
  localparam int unsigned IMEM_BYTE_W     = 8;
  localparam int unsigned IMEM_WORD_W     = IMEM_WORD_BYTES * IMEM_BYTE_W;
  localparam int unsigned IMEM_ADDR_W     = 32;
  localparam int unsigned IMEM_LANE_W     = 2;

  // Ceiling log2, usable in constant expressions for address widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch read port plus boot-loader byte stream between the core side and the responder.
interface imem_if;
  import imem_pkg::*;

  logic                   mem_valid;
  logic [IMEM_ADDR_W-1:0] mem_addr;
  logic [IMEM_WORD_W-1:0] mem_rdata;
  logic                   ld_valid;
  logic [IMEM_BYTE_W-1:0] ld_byte;
  logic                   ld_last;
  logic                   ld_ready;

  modport master (
    output mem_valid, mem_addr, ld_valid, ld_byte, ld_last,
    input  mem_rdata, ld_ready
  );

  modport slave (
    input  mem_valid, mem_addr, ld_valid, ld_byte, ld_last,
    output mem_rdata, ld_ready
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Assembles little-endian loader bytes into 32-bit words; flags the word on the 4th or last byte.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IMEM_BYTE_W-1:0] data,
  input  logic                   valid,
  input  logic                   last,
  output logic [IMEM_WORD_W-1:0] word,
  output logic                   word_we
);

  logic [IMEM_LANE_W-1:0] byte_cnt_q;
  logic [IMEM_WORD_W-1:0] asm_q;

  // Lanes above byte_cnt are always zero in asm_q, so a short final word is zero-padded.
  always_comb begin
    word    = asm_q | (IMEM_WORD_W'(data) << {byte_cnt_q, 3'b000});
    word_we = valid && ((byte_cnt_q == IMEM_LANE_W'(IMEM_WORD_BYTES - 1)) || last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else if (valid) begin
      if (word_we) begin
        byte_cnt_q <= '0;
        asm_q      <= '0;
      end else begin
        byte_cnt_q <= byte_cnt_q + IMEM_LANE_W'(1);
        asm_q      <= word;
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with zero-latency read port, filled after reset by a byte-stream boot loader.
// Optional macro IMEM_RELOAD_EN adds a reload input that returns RUN to LOAD.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned            WORDS             = 1024,
  parameter logic [IMEM_WORD_W-1:0] RESET_INSTRUCTION = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  imem_if.slave  bus,
`ifdef IMEM_RELOAD_EN
  input  logic   reload,
`endif
  output logic   hlt_req,
  output logic   boot_done,
  output logic   err_overflow,
  output logic   err_misaligned
);

  localparam int unsigned AW   = clog2(WORDS);
  localparam int unsigned WA_W = AW + 1;

  imem_state_t            state_q, state_d;
  logic [WA_W-1:0]        waddr_q;
  logic                   waddr_full;
  logic                   ld_ready_q;
  logic                   transfer;
  logic [IMEM_WORD_W-1:0] pk_word;
  logic                   pk_we;
  logic [AW-1:0]          rd_idx;
  logic                   addr_in_range;
  logic                   reload_req;
  logic [IMEM_WORD_W-1:0] mem [WORDS];

  assign bus.ld_ready = ld_ready_q;
  assign transfer     = bus.ld_valid && ld_ready_q;
  assign waddr_full   = (waddr_q == WA_W'(WORDS));

`ifdef IMEM_RELOAD_EN
  assign reload_req = (state_q == IMEM_RUN) && reload;
`else
  assign reload_req = 1'b0;
`endif

  imem_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .data    (bus.ld_byte),
    .valid   (transfer),
    .last    (bus.ld_last),
    .word    (pk_word),
    .word_we (pk_we)
  );

  // Next-state logic: LOAD ends on the last byte; RUN is left only through reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IMEM_LOAD: if (transfer && bus.ld_last) state_d = IMEM_RUN;
      IMEM_RUN:  if (reload_req)              state_d = IMEM_LOAD;
      default:                                state_d = IMEM_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IMEM_LOAD;
      hlt_req        <= 1'b1;
      boot_done      <= 1'b0;
      ld_ready_q     <= 1'b1;
      err_overflow   <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      state_q    <= state_d;
      hlt_req    <= (state_d == IMEM_LOAD);
      boot_done  <= (state_d == IMEM_RUN);
      ld_ready_q <= (state_d == IMEM_LOAD);
      if (pk_we && waddr_full)                        err_overflow   <= 1'b1;
      if (bus.mem_valid && (bus.mem_addr[1:0] != 2'b00)) err_misaligned <= 1'b1;
    end
  end

  // Write address saturates at WORDS so an oversized image still reaches its last byte.
  always_ff @(posedge clk) begin
    if (rst || reload_req) begin
      waddr_q <= '0;
    end else if (pk_we && !waddr_full) begin
      waddr_q <= waddr_q + WA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pk_we && !waddr_full) mem[waddr_q[AW-1:0]] <= pk_word;
  end

  assign rd_idx        = bus.mem_addr[AW+1:2];
  assign addr_in_range = ((bus.mem_addr >> (AW + 2)) == '0);

  always_comb begin
    bus.mem_rdata = RESET_INSTRUCTION;
    if ((state_q == IMEM_RUN) && bus.mem_valid &&
        (bus.mem_addr[1:0] == 2'b00) && addr_in_range) begin
      bus.mem_rdata = mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder: image-level reference model of memory contents and flags.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int unsigned WORDS = 4;
  localparam logic [31:0] RST_INSN = 32'hDEAD_BEEF;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst;
  logic hlt_req, boot_done, err_overflow, err_misaligned;
`ifdef IMEM_RELOAD_EN
  logic reload;
`endif

  imem_if bus ();

  imem_responder #(.WORDS(WORDS), .RESET_INSTRUCTION(RST_INSN)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
`ifdef IMEM_RELOAD_EN
    .reload         (reload),
`endif
    .hlt_req        (hlt_req),
    .boot_done      (boot_done),
    .err_overflow   (err_overflow),
    .err_misaligned (err_misaligned)
  );

  always #5 clk = ~clk;

  // Reference model: memory image, which words were ever written, and the two sticky flags.
  logic [31:0] m_mem [WORDS];
  bit          m_wr  [WORDS];
  bit          m_ovf, m_mis;
  int          n_checks = 0;
  int          n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Word w of an image holds bytes 4w..4w+3; a completed image pads its tail, an aborted one drops it.
  task automatic model_image(input byte_q_t b, input bit complete);
    int n  = b.size();
    int nw = complete ? (n + 3) / 4 : n / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] v = '0;
      for (int l = 0; l < 4; l++) if (4 * w + l < n) v[8*l +: 8] = b[4*w + l];
      if (w < int'(WORDS)) begin
        m_mem[w] = v;
        m_wr[w]  = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_status(input bit in_run);
    check_eq("hlt_req",        32'(hlt_req),        32'(!in_run));
    check_eq("boot_done",      32'(boot_done),      32'(in_run));
    check_eq("ld_ready",       32'(bus.ld_ready),   32'(!in_run));
    check_eq("err_overflow",   32'(err_overflow),   32'(m_ovf));
    check_eq("err_misaligned", 32'(err_misaligned), 32'(m_mis));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ovf = 1'b0;
    m_mis = 1'b0;
  endtask

  task automatic read_check(input logic [31:0] addr, input bit valid, input bit in_run);
    logic [31:0] exp;
    int          idx;
    bit          known;
    @(negedge clk);
    bus.ld_valid  = 1'b0;
    bus.mem_valid = valid;
    bus.mem_addr  = addr;
    #1;
    idx   = int'(addr >> 2);
    known = 1'b1;
    exp   = RST_INSN;
    if (in_run && valid && addr[1:0] == 2'b00 && addr < 32'(4 * WORDS)) begin
      known = m_wr[idx];
      exp   = m_mem[idx];
    end
    if (known) check_eq($sformatf("rdata@%0h", addr), bus.mem_rdata, exp);
    if (valid && addr[1:0] != 2'b00) m_mis = 1'b1;
  endtask

  task automatic check_all_reads();
    for (int w = 0; w < int'(WORDS); w++) read_check(32'(4 * w), 1'b1, 1'b1);
    read_check(32'(4 * WORDS), 1'b1, 1'b1);
    read_check(32'h8000_0000, 1'b1, 1'b1);
    read_check(32'h0, 1'b0, 1'b1);
    @(negedge clk);
    bus.mem_valid = 1'b0;
  endtask

  // Idle loader cycle, sometimes probing the read port (must return the reset word in LOAD).
  task automatic idle_probe();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_byte  = 8'($urandom);
    bus.mem_valid = 1'b0;
    if ($urandom_range(0, 1) == 1) begin
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 32'($urandom_range(0, WORDS)) << 2;
      if ($urandom_range(0, 7) == 0) bus.mem_addr[1:0] = 2'($urandom_range(1, 3));
      #1;
      check_eq("rdata_in_load", bus.mem_rdata, RST_INSN);
      if (bus.mem_addr[1:0] != 2'b00) m_mis = 1'b1;
    end
  endtask

  task automatic send_bytes(input byte_q_t b, input bit with_last);
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        idle_probe();
      end
      @(negedge clk);
      bus.mem_valid = 1'b0;
      bus.ld_valid  = 1'b1;
      bus.ld_byte   = b[i];
      bus.ld_last   = with_last && (i == b.size() - 1);
      check_eq("ld_ready_loading", 32'(bus.ld_ready), 32'd1);
      check_eq("hlt_req_loading",  32'(hlt_req),      32'd1);
    end
    @(negedge clk);
    bus.ld_valid  = 1'b0;
    bus.ld_last   = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    byte_q_t img;
    rst = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_addr = '0;
    bus.ld_valid = 1'b0; bus.ld_byte = '0; bus.ld_last = 1'b0;
`ifdef IMEM_RELOAD_EN
    reload = 1'b0;
`endif
    for (int w = 0; w < int'(WORDS); w++) m_wr[w] = 1'b0;

    do_reset();
    check_status(1'b0);
    read_check(32'h0, 1'b1, 1'b0);

    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_bytes(img, 1'b1);
    model_image(img, 1'b1);
    check_status(1'b1);
    read_check(32'h4, 1'b1, 1'b1);
    check_eq("boot_word1", bus.mem_rdata, 32'h0010_0093);
    read_check(32'h10, 1'b1, 1'b1);
    check_all_reads();

    read_check(32'h2, 1'b1, 1'b1);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    check_eq("misaligned_set", 32'(err_misaligned), 32'd1);
    @(negedge clk);
    check_eq("misaligned_sticky", 32'(err_misaligned), 32'd1);

    // Loader traffic in RUN must be ignored.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_byte  = 8'($urandom);
      bus.ld_last  = 1'($urandom);
      check_eq("ld_ready_run", 32'(bus.ld_ready), 32'd0);
    end
    @(negedge clk);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    check_status(1'b1);
    check_all_reads();

    do_reset();
    check_status(1'b0);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_bytes(img, 1'b1);
    model_image(img, 1'b1);
    check_status(1'b1);
    read_check(32'h4, 1'b1, 1'b1);
    check_eq("pad_word", bus.mem_rdata, 32'h0000_00EE);
    check_all_reads();

    do_reset();
    img = rand_bytes(20);
    send_bytes(img, 1'b1);
    model_image(img, 1'b1);
    check_eq("overflow_set", 32'(err_overflow), 32'd1);
    check_status(1'b1);
    check_all_reads();

    do_reset();
    img = rand_bytes(6);
    send_bytes(img, 1'b0);
    model_image(img, 1'b0);
    do_reset();
    check_status(1'b0);
    img = rand_bytes(3);
    send_bytes(img, 1'b1);
    model_image(img, 1'b1);
    check_status(1'b1);
    check_all_reads();

    for (int it = 0; it < 10; it++) begin
      do_reset();
      img = rand_bytes($urandom_range(1, 20));
      send_bytes(img, 1'b1);
      model_image(img, 1'b1);
      check_status(1'b1);
      check_all_reads();
    end

`ifdef IMEM_RELOAD_EN
    read_check(32'h1, 1'b1, 1'b1);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_status(1'b0);
    img = rand_bytes(7);
    send_bytes(img, 1'b1);
    model_image(img, 1'b1);
    check_status(1'b1);
    check_all_reads();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
